// File: rtl/sha_hex_pkg.sv
// Shared definitions for the sha512 digest-to-hex-text serializer.
//   CH_SP / CH_NL : separator and record terminator bytes
//   REC_BYTES     : bytes in one emitted text record
//   hex_char      : nibble -> lowercase ASCII hex digit
//   state_e       : serializer FSM states
package sha_hex_pkg;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_NL = 8'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StId,
        StSp,
        StDig,
        StNl
    } state_e;

    // id chars + space + digest chars + newline
    function automatic int unsigned REC_BYTES(input int unsigned id_bits,
                                              input int unsigned digest_bits);
        return id_bits / 4 + digest_bits / 4 + 2;
    endfunction

    // 0..9 -> '0'..'9', 10..15 -> 'a'..'f'
    function automatic logic [7:0] hex_char(input logic [3:0] nibble);
        logic [7:0] ch;
        if (nibble < 4'd10) begin
            ch = 8'h30 + {4'h0, nibble};
        end else begin
            ch = 8'h57 + {4'h0, nibble};
        end
        return ch;
    endfunction

endpackage

// File: rtl/sha_rec_fifo.sv
// Record FIFO between the sha512 result pulse and the hex serializer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write strobe and record; ignored when full unless popping this cycle
//   pop           : remove the head record (ignored when empty)
//   rdata         : head record (combinational read)
//   rdata_next    : record behind the head, valid when more=1
//   full, empty   : occupancy flags
//   more          : at least two records stored
module sha_rec_fifo #(
    parameter int unsigned WIDTH = 544,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] rdata_next,
    output logic             full,
    output logic             empty,
    output logic             more
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        more  = (count_q > (AW + 1)'(1));

        do_pop  = pop & ~empty;
        // A pop frees the head slot this cycle, so a push at full still fits.
        do_push = push & (~full | do_pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // Read-first: at full with push+pop, wr_ptr == rd_ptr; the head is read
    // combinationally this cycle and overwritten at the edge.
    assign rdata      = mem_q[rd_ptr_q];
    assign rdata_next = mem_q[rd_ptr_q + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sha_digest_hexout.sv
// Converts sha512 result pulses into lowercase hex text lines on a byte stream.
// Each record: ID_BITS/4 id chars, ' ', DIGEST_BITS/4 digest chars, '\n'.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   ivalid, iid, isha: one-cycle result strobe, id and digest (no backpressure)
//   tvalid, tready   : output byte handshake (registered, tvalid independent of tready)
//   tdata, tlast     : ASCII byte, high on each record's newline
//   overflow         : sticky, set when a result was dropped at a full FIFO
module sha_digest_hexout
    import sha_hex_pkg::*;
#(
    parameter int unsigned ID_BITS     = 32,
    parameter int unsigned DIGEST_BITS = 512,
    parameter int unsigned FIFO_AW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ivalid,
    input  logic [ID_BITS-1:0]     iid,
    input  logic [DIGEST_BITS-1:0] isha,
    output logic                   tvalid,
    input  logic                   tready,
    output logic [7:0]             tdata,
    output logic                   tlast,
    output logic                   overflow
);

    localparam int unsigned ID_N  = ID_BITS / 4;
    localparam int unsigned DIG_N = DIGEST_BITS / 4;
    localparam int unsigned MAX_N = (ID_N > DIG_N) ? ID_N : DIG_N;
    localparam int unsigned CNT_W = $clog2(MAX_N + 1);
    localparam int unsigned REC_W = ID_BITS + DIGEST_BITS;

    localparam logic [CNT_W-1:0] ID_LAST  = CNT_W'(ID_N - 1);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIG_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (ID_BITS == 0 || (ID_BITS % 4) != 0) begin : g_bad_id_bits
        $error("ID_BITS must be a non-zero multiple of 4");
    end
    if (DIGEST_BITS == 0 || (DIGEST_BITS % 4) != 0) begin : g_bad_digest_bits
        $error("DIGEST_BITS must be a non-zero multiple of 4");
    end

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    logic             fifo_full, fifo_empty, fifo_more;
    logic             pop;
    logic [REC_W-1:0] fifo_rdata, fifo_rdata_next;

    sha_rec_fifo #(
        .WIDTH (REC_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (ivalid),
        .wdata      ({iid, isha}),
        .pop        (pop),
        .rdata      (fifo_rdata),
        .rdata_next (fifo_rdata_next),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .more       (fifo_more)
    );

    logic [ID_BITS-1:0]     head_id, next_id;
    logic [DIGEST_BITS-1:0] head_dig, next_dig;

    assign head_id  = fifo_rdata[REC_W-1 -: ID_BITS];
    assign head_dig = fifo_rdata[DIGEST_BITS-1:0];
    assign next_id  = fifo_rdata_next[REC_W-1 -: ID_BITS];
    assign next_dig = fifo_rdata_next[DIGEST_BITS-1:0];

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ID_BITS-1:0]     sr_id_q, sr_id_d;
    logic [DIGEST_BITS-1:0] sr_dig_q, sr_dig_d;
    logic                   tvalid_q, tvalid_d;
    logic [7:0]             tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic                   overflow_q, overflow_d;

    logic load_en;
    logic accept;

    // Output register may take a new byte when empty or being drained now.
    assign load_en = ~tvalid_q | tready;
    assign accept  = tvalid_q & tready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_id_d    = sr_id_q;
        sr_dig_d   = sr_dig_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        pop        = 1'b0;

        if (accept) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    sr_id_d  = head_id;
                    sr_dig_d = head_dig;
                    cnt_d    = '0;
                    state_d  = StId;
                end
            end

            StId: begin
                if (load_en) begin
                    tvalid_d = 1'b1;
                    tdata_d  = hex_char(sr_id_q[ID_BITS-1 -: 4]);
                    tlast_d  = 1'b0;
                    sr_id_d  = sr_id_q << 4;
                    if (cnt_q == ID_LAST) begin
                        cnt_d   = '0;
                        state_d = StSp;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            StSp: begin
                if (load_en) begin
                    tvalid_d = 1'b1;
                    tdata_d  = CH_SP;
                    tlast_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = StDig;
                end
            end

            StDig: begin
                if (load_en) begin
                    tvalid_d = 1'b1;
                    tdata_d  = hex_char(sr_dig_q[DIGEST_BITS-1 -: 4]);
                    tlast_d  = 1'b0;
                    sr_dig_d = sr_dig_q << 4;
                    if (cnt_q == DIG_LAST) begin
                        cnt_d   = '0;
                        state_d = StNl;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            StNl: begin
                // tlast_q distinguishes "newline still to load" from
                // "newline sitting in the output register".
                if (!tlast_q) begin
                    if (load_en) begin
                        tvalid_d = 1'b1;
                        tdata_d  = CH_NL;
                        tlast_d  = 1'b1;
                    end
                end else if (tready) begin
                    pop = 1'b1;
                    if (fifo_more) begin
                        // Next record sits behind the head being popped; start it
                        // in the same edge so the stream has no bubble.
                        sr_id_d  = next_id << 4;
                        sr_dig_d = next_dig;
                        tvalid_d = 1'b1;
                        tdata_d  = hex_char(next_id[ID_BITS-1 -: 4]);
                        tlast_d  = 1'b0;
                        if (ID_N == 1) begin
                            cnt_d   = '0;
                            state_d = StSp;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = StId;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        overflow_d = overflow_q | (ivalid & fifo_full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sr_id_q    <= '0;
            sr_dig_q   <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_id_q    <= sr_id_d;
            sr_dig_q   <= sr_dig_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            overflow_q <= overflow_d;
        end
    end

    assign tvalid   = tvalid_q;
    assign tdata    = tdata_q;
    assign tlast    = tlast_q;
    assign overflow = overflow_q;

endmodule
